// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the line-transfer memory arbiter.
package mem_arb_pkg;

   localparam int LINE_W = 128;
   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      RESPOND   = 2'd3
   } arb_state_t;

   // Encoding matches the bit position in the two-bit request/grant vectors.
   typedef enum logic {
      ICACHE = 1'b0,
      DCACHE = 1'b1
   } requester_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic              rw;
   } line_req_t;

   // Forces a byte address onto its 16-byte line boundary.
   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
      return a & ~{{(ADDR_W-4){1'b0}}, 4'hF};
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with its own last-winner register.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       RESET,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] grant
);

   requester_t last_grant;

   // One-hot grant; on a tie the requester that did not win last time goes.
   always_comb begin
      grant = 2'b00;
      if (en) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == DCACHE) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // Remember the most recent winner; reset favours the icache on the first tie.
   always_ff @(posedge clk) begin
      if (!RESET)
         last_grant <= DCACHE;
      else if (grant != 2'b00)
         last_grant <= grant[1] ? DCACHE : ICACHE;
   end

endmodule

// File: rtl/line_mem_arbiter.sv
// Shares one 128-bit line memory port between the icache and dcache,
// one transaction in flight, with a response watchdog.
//
// Handshake: a requester holds *_req_valid and its payload until it sees a
// one-cycle *_req_ready pulse; the memory side holds mem_req_valid and the
// request fields stable until the cycle mem_req_ready is high. A transfer
// occurs only in a cycle where valid and ready are both high.
module line_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_ready,
   output logic              ic_resp_valid,
   output logic [LINE_W-1:0] ic_resp_data,
   input  logic              dc_req_valid,
   input  logic              dc_req_rw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   input  logic [LINE_W-1:0] dc_req_wdata,
   output logic              dc_req_ready,
   output logic              dc_resp_valid,
   output logic [LINE_W-1:0] dc_resp_data,
   output logic              mem_req_valid,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [LINE_W-1:0] mem_req_wdata,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [LINE_W-1:0] mem_resp_data,
   output logic              err_timeout,
   output arb_state_t        dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_t         state_q, state_d;
   requester_t         owner_q;
   line_req_t          req_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               err_q;
   logic [LINE_W-1:0]  ic_data_q, dc_data_q;
   logic [1:0]         grant;
   logic               arb_en;
   logic               timeout_hit;

   // Arbitration only happens in IDLE and never while reset is asserted.
   assign arb_en      = RESET && (state_q == IDLE);
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .RESET (RESET),
      .req   ({dc_req_valid, ic_req_valid}),
      .en    (arb_en),
      .grant (grant)
   );

   assign mem_req_rw    = req_q.rw;
   assign mem_req_addr  = req_q.addr;
   assign mem_req_wdata = req_q.wdata;
   assign ic_resp_data  = ic_data_q;
   assign dc_resp_data  = dc_data_q;
   assign err_timeout   = err_q;
   assign dbg_state     = state_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!RESET)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next-state and handshake outputs; a response beats a same-cycle timeout.
   always_comb begin
      state_d       = state_q;
      ic_req_ready  = grant[0];
      dc_req_ready  = grant[1];
      mem_req_valid = 1'b0;
      ic_resp_valid = 1'b0;
      dc_resp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant != 2'b00)
               state_d = ISSUE;
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready)
               state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (mem_resp_valid || timeout_hit)
               state_d = RESPOND;
         end
         RESPOND: begin
            ic_resp_valid = (owner_q == ICACHE);
            dc_resp_valid = (owner_q == DCACHE);
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch, watchdog counter, sticky error and per-requester response data.
   always_ff @(posedge clk) begin
      if (!RESET) begin
         owner_q   <= ICACHE;
         req_q     <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         ic_data_q <= '0;
         dc_data_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant[1]) begin
                  owner_q     <= DCACHE;
                  req_q.rw    <= dc_req_rw;
                  req_q.addr  <= line_align(dc_req_addr);
                  req_q.wdata <= dc_req_rw ? dc_req_wdata : '0;
               end else if (grant[0]) begin
                  owner_q     <= ICACHE;
                  req_q.rw    <= 1'b0;
                  req_q.addr  <= line_align(ic_req_addr);
                  req_q.wdata <= '0;
               end
            end
            ISSUE: begin
               if (mem_req_ready)
                  cnt_q <= '0;
            end
            WAIT_RESP: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (mem_resp_valid) begin
                  if (owner_q == ICACHE)
                     ic_data_q <= req_q.rw ? '0 : mem_resp_data;
                  else
                     dc_data_q <= req_q.rw ? '0 : mem_resp_data;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
                  if (owner_q == ICACHE)
                     ic_data_q <= '0;
                  else
                     dc_data_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed self-checking bench for line_mem_arbiter (watchdog set to 8 cycles).
module tb_line_mem_arbiter;
  import mem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              RESET = 1'b0;
  logic              ic_req_valid = 1'b0;
  logic [ADDR_W-1:0] ic_req_addr = '0;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic [LINE_W-1:0] ic_resp_data;
  logic              dc_req_valid = 1'b0;
  logic              dc_req_rw = 1'b0;
  logic [ADDR_W-1:0] dc_req_addr = '0;
  logic [LINE_W-1:0] dc_req_wdata = '0;
  logic              dc_req_ready;
  logic              dc_resp_valid;
  logic [LINE_W-1:0] dc_resp_data;
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_req_ready = 1'b0;
  logic              mem_resp_valid = 1'b0;
  logic [LINE_W-1:0] mem_resp_data = '0;
  logic              err_timeout;
  arb_state_t        dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [LINE_W-1:0] IC_DATA = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [LINE_W-1:0] WB_DATA = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
  localparam logic [LINE_W-1:0] FU_DATA = 128'hFEEDF00D_00000000_12345678_CAFE0001;

  line_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .RESET          (RESET),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .dc_req_valid   (dc_req_valid),
    .dc_req_rw      (dc_req_rw),
    .dc_req_addr    (dc_req_addr),
    .dc_req_wdata   (dc_req_wdata),
    .dc_req_ready   (dc_req_ready),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_data   (dc_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .err_timeout    (err_timeout),
    .dbg_state      (dbg_state)
  );

  // Clock and global time limit
  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, time %0t limit 100000", $time);
    $fatal(1, "bench time limit reached");
  end

  task automatic test_reset();
    RESET = 1'b0;
    ic_req_valid = 1'b1;
    dc_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++; if (ic_req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ic_ready: got %0b exp 0", ic_req_ready); end
    tests_run++; if (dc_req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_dc_ready: got %0b exp 0", dc_req_ready); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE); end
    tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_valid: got %0b exp 0", mem_req_valid); end
    tests_run++; if (mem_req_addr !== '0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h exp 0", mem_req_addr); end
    tests_run++; if (mem_req_wdata !== '0) begin tests_failed++; $display("FAIL reset_mem_wdata: got %h exp 0", mem_req_wdata); end
    tests_run++; if (err_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %0b exp 0", err_timeout); end
    tests_run++; if ((ic_resp_valid | dc_resp_valid) !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %0b%0b exp 00", ic_resp_valid, dc_resp_valid); end
    tests_run++; if ((ic_resp_data | dc_resp_data) !== '0) begin tests_failed++; $display("FAIL reset_resp_data: got %h %h exp 0", ic_resp_data, dc_resp_data); end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    RESET = 1'b1;
  endtask

  task automatic test_ic_fill();
    @(negedge clk);
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_1234;
    #1;
    tests_run++; if (ic_req_ready !== 1'b1) begin tests_failed++; $display("FAIL ic_fill_ready: got %0b exp 1", ic_req_ready); end
    tests_run++; if (dc_req_ready !== 1'b0) begin tests_failed++; $display("FAIL ic_fill_dc_ready: got %0b exp 0", dc_req_ready); end
    @(negedge clk);
    ic_req_valid = 1'b0;
    ic_req_addr  = '0;
    tests_run++; if (ic_req_ready !== 1'b0) begin tests_failed++; $display("FAIL ic_fill_ready_pulse: got %0b exp 0", ic_req_ready); end
    tests_run++; if (mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL ic_fill_mem_valid: got %0b exp 1", mem_req_valid); end
    tests_run++; if (mem_req_addr !== 32'h0000_1230) begin tests_failed++; $display("FAIL ic_fill_mem_addr: got %h exp 00001230", mem_req_addr); end
    tests_run++; if (mem_req_rw !== 1'b0) begin tests_failed++; $display("FAIL ic_fill_mem_rw: got %0b exp 0", mem_req_rw); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL ic_fill_mem_valid_drop: got %0b exp 0", mem_req_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++; if ({ic_resp_valid, dc_resp_valid, dc_req_ready, mem_req_valid} !== 4'b0000) begin tests_failed++; $display("FAIL ic_fill_wait_quiet: cycle %0d got %b exp 0000", i, {ic_resp_valid, dc_resp_valid, dc_req_ready, mem_req_valid}); end
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = IC_DATA;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    tests_run++; if (ic_resp_valid !== 1'b1) begin tests_failed++; $display("FAIL ic_fill_resp_valid: got %0b exp 1", ic_resp_valid); end
    tests_run++; if (ic_resp_data !== IC_DATA) begin tests_failed++; $display("FAIL ic_fill_resp_data: got %h exp %h", ic_resp_data, IC_DATA); end
    tests_run++; if (dc_resp_valid !== 1'b0) begin tests_failed++; $display("FAIL ic_fill_dc_resp: got %0b exp 0", dc_resp_valid); end
    @(negedge clk);
    tests_run++; if (ic_resp_valid !== 1'b0) begin tests_failed++; $display("FAIL ic_fill_resp_pulse: got %0b exp 0", ic_resp_valid); end
    tests_run++; if (ic_resp_data !== IC_DATA) begin tests_failed++; $display("FAIL ic_fill_resp_hold: got %h exp %h", ic_resp_data, IC_DATA); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL ic_fill_back_idle: got %0d exp %0d", dbg_state, IDLE); end
  endtask

  task automatic test_round_robin();
    logic             exp_dc;
    logic [LINE_W-1:0] data;
    RESET = 1'b0;
    @(negedge clk);
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_0100;
    dc_req_valid = 1'b1;
    dc_req_rw    = 1'b0;
    dc_req_addr  = 32'h0000_2008;
    @(negedge clk);
    RESET = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_dc = (g % 2) == 1;
      data   = {4{32'hA5A5_0000 + 32'(g)}};
      tests_run++; if ({dc_req_ready, ic_req_ready} !== {exp_dc, ~exp_dc}) begin tests_failed++; $display("FAIL rr_grant_%0d: got dc/ic %b exp %b", g, {dc_req_ready, ic_req_ready}, {exp_dc, ~exp_dc}); end
      @(negedge clk);
      tests_run++; if (mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rr_mem_valid_%0d: got %0b exp 1", g, mem_req_valid); end
      tests_run++; if (mem_req_addr !== (exp_dc ? 32'h0000_2000 : 32'h0000_0100)) begin tests_failed++; $display("FAIL rr_mem_addr_%0d: got %h exp %h", g, mem_req_addr, exp_dc ? 32'h0000_2000 : 32'h0000_0100); end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready  = 1'b0;
      tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_one_req_%0d: got %0b exp 0", g, mem_req_valid); end
      mem_resp_valid = 1'b1;
      mem_resp_data  = data;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      tests_run++; if ({dc_resp_valid, ic_resp_valid} !== {exp_dc, ~exp_dc}) begin tests_failed++; $display("FAIL rr_resp_%0d: got dc/ic %b exp %b", g, {dc_resp_valid, ic_resp_valid}, {exp_dc, ~exp_dc}); end
      tests_run++; if ((exp_dc ? dc_resp_data : ic_resp_data) !== data) begin tests_failed++; $display("FAIL rr_data_%0d: got %h exp %h", g, exp_dc ? dc_resp_data : ic_resp_data, data); end
      @(negedge clk);
      #1;
    end
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
  endtask

  task automatic test_dc_writeback();
    @(negedge clk);
    dc_req_valid = 1'b1;
    dc_req_rw    = 1'b1;
    dc_req_addr  = 32'h8000_0040;
    dc_req_wdata = WB_DATA;
    #1;
    tests_run++; if ({dc_req_ready, ic_req_ready} !== 2'b10) begin tests_failed++; $display("FAIL wb_ready: got dc/ic %b exp 10", {dc_req_ready, ic_req_ready}); end
    @(negedge clk);
    dc_req_valid = 1'b0;
    dc_req_rw    = 1'b0;
    dc_req_addr  = '1;
    dc_req_wdata = '0;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if ({mem_req_valid, mem_req_rw} !== 2'b11) begin tests_failed++; $display("FAIL wb_hold_ctl_%0d: got valid/rw %b exp 11", i, {mem_req_valid, mem_req_rw}); end
      tests_run++; if (mem_req_addr !== 32'h8000_0040) begin tests_failed++; $display("FAIL wb_hold_addr_%0d: got %h exp 80000040", i, mem_req_addr); end
      tests_run++; if (mem_req_wdata !== WB_DATA) begin tests_failed++; $display("FAIL wb_hold_wdata_%0d: got %h exp %h", i, mem_req_wdata, WB_DATA); end
      if (i == 4) mem_req_ready = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    tests_run++; if (mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL wb_mem_valid_drop: got %0b exp 0", mem_req_valid); end
    mem_resp_valid = 1'b1;
    mem_resp_data  = '1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    tests_run++; if ({dc_resp_valid, ic_resp_valid} !== 2'b10) begin tests_failed++; $display("FAIL wb_resp_valid: got dc/ic %b exp 10", {dc_resp_valid, ic_resp_valid}); end
    tests_run++; if (dc_resp_data !== '0) begin tests_failed++; $display("FAIL wb_resp_data: got %h exp 0", dc_resp_data); end
    @(negedge clk);
    tests_run++; if (dc_resp_valid !== 1'b0) begin tests_failed++; $display("FAIL wb_resp_pulse: got %0b exp 0", dc_resp_valid); end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_0040;
    #1;
    tests_run++; if (ic_req_ready !== 1'b1) begin tests_failed++; $display("FAIL to_ready: got %0b exp 1", ic_req_ready); end
    @(negedge clk);
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      tests_run++; if ({dbg_state, err_timeout, ic_resp_valid} !== {WAIT_RESP, 2'b00}) begin tests_failed++; $display("FAIL to_wait_%0d: got state %0d err %0b resp %0b exp state %0d err 0 resp 0", i, dbg_state, err_timeout, ic_resp_valid, WAIT_RESP); end
    end
    @(negedge clk);
    tests_run++; if (dbg_state !== RESPOND) begin tests_failed++; $display("FAIL to_state: got %0d exp %0d", dbg_state, RESPOND); end
    tests_run++; if (err_timeout !== 1'b1) begin tests_failed++; $display("FAIL to_err: got %0b exp 1", err_timeout); end
    tests_run++; if (ic_resp_valid !== 1'b1) begin tests_failed++; $display("FAIL to_resp_valid: got %0b exp 1", ic_resp_valid); end
    tests_run++; if (ic_resp_data !== '0) begin tests_failed++; $display("FAIL to_resp_data: got %h exp 0", ic_resp_data); end
    @(negedge clk);
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_0088;
    #1;
    tests_run++; if (ic_req_ready !== 1'b1) begin tests_failed++; $display("FAIL to_next_ready: got %0b exp 1", ic_req_ready); end
    @(negedge clk);
    ic_req_valid  = 1'b0;
    tests_run++; if (mem_req_addr !== 32'h0000_0080) begin tests_failed++; $display("FAIL to_next_addr: got %h exp 00000080", mem_req_addr); end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = FU_DATA;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    tests_run++; if ({ic_resp_valid, err_timeout} !== 2'b11) begin tests_failed++; $display("FAIL to_next_resp: got resp/err %b exp 11", {ic_resp_valid, err_timeout}); end
    tests_run++; if (ic_resp_data !== FU_DATA) begin tests_failed++; $display("FAIL to_next_data: got %h exp %h", ic_resp_data, FU_DATA); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_00C0;
    @(negedge clk);
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (dbg_state !== WAIT_RESP) begin tests_failed++; $display("FAIL rm_pre_state: got %0d exp %0d", dbg_state, WAIT_RESP); end
    RESET = 1'b0;
    @(negedge clk);
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL rm_state: got %0d exp %0d", dbg_state, IDLE); end
    tests_run++; if ({ic_resp_valid, dc_resp_valid, mem_req_valid, err_timeout} !== 4'b0000) begin tests_failed++; $display("FAIL rm_ctl: got %b exp 0000", {ic_resp_valid, dc_resp_valid, mem_req_valid, err_timeout}); end
    tests_run++; if (mem_req_addr !== '0) begin tests_failed++; $display("FAIL rm_addr: got %h exp 0", mem_req_addr); end
    tests_run++; if (ic_resp_data !== '0) begin tests_failed++; $display("FAIL rm_data: got %h exp 0", ic_resp_data); end
    RESET = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_data  = IC_DATA;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    for (int i = 0; i < 2; i++) begin
      tests_run++; if ({dbg_state, ic_resp_valid} !== {IDLE, 1'b0}) begin tests_failed++; $display("FAIL rm_late_%0d: got state %0d resp %0b exp state %0d resp 0", i, dbg_state, ic_resp_valid, IDLE); end
      tests_run++; if (ic_resp_data !== '0) begin tests_failed++; $display("FAIL rm_late_data_%0d: got %h exp 0", i, ic_resp_data); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_ic_fill();
    test_round_robin();
    test_dc_writeback();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
